pool_cmd_gen: RTL and testbench
===============================

# pool_cmd_gen

Command sequencer that drives the Pool engine's processing-element array. It accepts one pooling job (mode, window size, active accumulator slots) and walks window elements × slots, issuing one-hot `{end, max, avg, start}` commands plus slot select and delayed slot select to every PE in lock-step with the input pixel stream. It sits between the Pool engine's job dispatcher and its PE array, and reports job completion aligned with the PEs' final `y_vld`.

## Interface
- `S`, default 32: engine width. The PEs hold `S/2` accumulator slots; `SW = $clog2(S/2)`.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `job_vld`  in  1  job descriptor valid.
- `job_rdy`  out  1  ready for a job; high only in IDLE.
- `job_mode`  in  1  0 = average (sum), 1 = max.
- `job_k`  in  7  window element count K (kh·kw).
- `job_n`  in  SW+1  active slots N, legal range 1..S/2.
- `in_vld`  in  1  upstream pixel beat valid; one beat carries x for all PEs.
- `in_rdy`  out  1  beat accepted when `in_vld & in_rdy`.
- `cmd`  out  4  `{end, max, avg, start}` to PEs; registered.
- `sel`  out  SW  slot index for `cmd`; registered.
- `sel_delay`  out  SW  `sel` delayed one cycle (PE output mux select).
- `busy`  out  1  high in RUN or FLUSH.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  one-cycle pulse, coincident with `done`, for a rejected job.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE:
  - `job_rdy = 1`.
  - On `job_vld`, latch mode, K and N; clear counters `k = 0`, `s = 0`.
  - Rejected jobs (K = 0, N = 0, N > S/2, or avg mode with K > 64) take one cycle: `done = err = 1`, no commands issued, remain in IDLE.
  - Otherwise go to RUN.
- RUN:
  - `in_rdy = 1`.
  - On each accepted beat, register a command for slot `s`:
    - `start` if `k == 0`.
    - Otherwise `avg` or `max` per mode.
    - `end` is ORed in when `k == K-1`.
  - Exactly one of start/avg/max is set per issued command.
  - Counter update on accept: `s` increments; at `s == N-1` it wraps to 0 and `k` increments.
  - On the beat with `k == K-1` and `s == N-1`, go to FLUSH.
  - No accept (bubble): `cmd = 0`; `sel` holds its value.
- FLUSH:
  - `in_rdy = 0`, `cmd = 0`.
  - Lasts 2 cycles, so that `done` coincides with the `y_vld` of the final slot.
  - Then IDLE.
- K = 1: every command is `start|end`.
- Accumulator bound: 14-bit PE registers.
  - Avg mode K ≤ 64 guarantees 255·64 = 16320 < 2^14.
  - Max mode accepts K up to 127.
- `sel_delay` is a plain register of `sel` and updates every cycle, including bubbles.
- Reset mid-job: immediate return to IDLE, counters cleared, `cmd` forced to 0 asynchronously. Partially accumulated PE slots are abandoned; no `done`.

## Timing
- Reset values: `cmd = 0`, `sel = 0`, `sel_delay = 0`, `in_rdy = 0`, `busy = 0`, `done = 0`, `err = 0`. `job_rdy = 1` (state IDLE).
- Beat accepted at edge t:
  - `cmd`/`sel` are valid in cycle t+1.
  - The PE updates at edge t+1.
  - For an end command, PE `y_vld` is high in cycle t+2, with `sel_delay` equal to that slot.
- The upstream data path registers x on the same accept strobe, so x and `cmd` arrive together at the PEs.
- Last beat accepted at edge t: FLUSH in cycles t+1 and t+2; `done` high in cycle t+2; `job_rdy` high from cycle t+3.
- Job latched at edge j: `in_rdy` high from cycle j+1.
- Throughput: one command per cycle with `in_vld` held high. A full job takes K·N + 3 cycles from job accept to `done`.
- `in_rdy` does not depend combinationally on `in_vld`.

## Test plan
- Reset, then idle:
  - All outputs at their reset values.
  - `job_rdy = 1`.
  - Assert `rst` mid-RUN: `cmd` goes to 0 within the same cycle and the block returns to IDLE.
- Avg job, K = 4, N = 3, `in_vld` held high:
  - 12 commands: 3× start with `sel` 0,1,2; 6× avg; 3× `avg|end`.
  - `done` in the cycle after the third end command appears.
  - Total 15 cycles from job accept to `done`.
- Max job, K = 1, N = 16 (S = 32):
  - 16 `start|end` commands, `sel` 0..15.
  - `sel_delay` trails `sel` by one cycle.
  - `sel` wraps from 15 to 0 with no glitch command.
- Bubbles: avg K = 2, N = 2, with `in_vld` low on alternate cycles:
  - `cmd = 0` on every non-accept cycle.
  - Command order unchanged.
  - `done` timing is still relative to the last accept.
- Rejections (K = 0; N = 17; avg with K = 65):
  - Each gives a single-cycle `done = err = 1`.
  - No nonzero `cmd`; `job_rdy` stays 1.
- Back-to-back:
  - Max K = 127, N = 1, then avg K = 64, N = 16.
  - Second job is accepted the cycle after the first `done`.
  - Counters are fully reset between jobs.

Source files
------------

// File: rtl/pool_cmd_gen.sv
// Pool PE command sequencer: walks K window elements x N slots, one {end,max,avg,start} command per accepted beat.
// Latency: cmd/sel one cycle after accept, done two cycles after last accept; in_rdy is state-only, never depends on in_vld.
module pool_cmd_gen #(
  parameter int S = 32,
  localparam int SW = $clog2(S/2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_vld,
  output logic          job_rdy,
  input  logic          job_mode,
  input  logic [6:0]    job_k,
  input  logic [SW:0]   job_n,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic [3:0]    cmd,
  output logic [SW-1:0] sel,
  output logic [SW-1:0] sel_delay,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_nstate;
  logic          r_mode;
  logic [6:0]    r_k;
  logic [6:0]    r_k_last;
  logic [SW-1:0] r_s;
  logic [SW-1:0] r_s_last;
  logic          r_fl;
  logic [3:0]    r_cmd;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_sel_d;
  logic          r_done;
  logic          r_err;

  logic w_accept;
  logic w_job_bad;
  logic w_last_beat;

  // Avg mode is capped at K=64 so 255*K still fits the 14-bit PE accumulator.
  assign w_job_bad   = (job_k == 7'd0) || (job_n == '0) ||
                       (job_n > (SW+1)'(S/2)) || (!job_mode && (job_k > 7'd64));
  assign w_accept    = (r_state == ST_RUN) && in_vld;
  assign w_last_beat = (r_k == r_k_last) && (r_s == r_s_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (job_vld && !w_job_bad) w_nstate = ST_RUN;
      ST_RUN:   if (w_accept && w_last_beat) w_nstate = ST_FLUSH;
      ST_FLUSH: if (r_fl) w_nstate = ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 1'b0;
      r_k      <= '0;
      r_k_last <= '0;
      r_s      <= '0;
      r_s_last <= '0;
      r_fl     <= 1'b0;
      r_cmd    <= '0;
      r_sel    <= '0;
      r_sel_d  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sel_d <= r_sel;
      r_cmd   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (job_vld) begin
            r_mode   <= job_mode;
            r_k_last <= job_k - 7'd1;
            r_s_last <= job_n[SW-1:0] - SW'(1);
            r_k      <= '0;
            r_s      <= '0;
            r_fl     <= 1'b0;
            if (w_job_bad) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_cmd <= {r_k == r_k_last,
                      r_mode && (r_k != 7'd0),
                      !r_mode && (r_k != 7'd0),
                      r_k == 7'd0};
            r_sel <= r_s;
            if (r_s == r_s_last) begin
              r_s <= '0;
              r_k <= r_k + 7'd1;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        ST_FLUSH: begin
          // Second flush cycle lines up with y_vld of the final slot.
          r_fl <= ~r_fl;
          if (!r_fl) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign job_rdy   = (r_state == ST_IDLE);
  assign in_rdy    = (r_state == ST_RUN);
  assign busy      = (r_state != ST_IDLE);
  assign cmd       = r_cmd;
  assign sel       = r_sel;
  assign sel_delay = r_sel_d;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_pool_cmd_gen.sv
// Directed bench for pool_cmd_gen: expected commands are queued at each accepted beat and checked when they appear.
module tb_pool_cmd_gen;

  localparam int S  = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          job_vld;
  logic          job_rdy;
  logic          job_mode;
  logic [6:0]    job_k;
  logic [SW:0]   job_n;
  logic          in_vld;
  logic          in_rdy;
  logic [3:0]    cmd;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_delay;
  logic          busy;
  logic          done;
  logic          err;

  pool_cmd_gen #(.S(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .job_vld   (job_vld),
    .job_rdy   (job_rdy),
    .job_mode  (job_mode),
    .job_k     (job_k),
    .job_n     (job_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .cmd       (cmd),
    .sel       (sel),
    .sel_delay (sel_delay),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [3:0]    c;
    logic [SW-1:0] s;
  } exp_t;

  exp_t          sb_q[$];
  logic [SW-1:0] exp_sel;
  logic [SW-1:0] exp_sel_d;
  int            n_vec;
  int            n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check cmd/sel/sel_delay against the scoreboard.
  task automatic tick(input logic acc);
    exp_t       e;
    logic [3:0] exp_cmd;
    @(posedge clk);
    #1;
    exp_sel_d = exp_sel;
    exp_cmd   = 4'd0;
    if (acc) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e       = sb_q.pop_front();
        exp_cmd = e.c;
        exp_sel = e.s;
      end
    end
    chk("cmd", 32'(cmd), 32'(exp_cmd));
    chk("sel", 32'(sel), 32'(exp_sel));
    chk("sel_delay", 32'(sel_delay), 32'(exp_sel_d));
  endtask

  function automatic exp_t beat_exp(input logic mode, input int k, input int n, input int b);
    exp_t e;
    int   ki;
    ki    = b / n;
    e.s   = SW'(b % n);
    e.c   = (ki == 0) ? 4'b0001 : (mode ? 4'b0100 : 4'b0010);
    if (ki == k - 1) e.c = e.c | 4'b1000;
    return e;
  endfunction

  task automatic run_job(input logic mode, input int k, input int n, input logic bub);
    int   total;
    int   beats;
    int   cyc;
    logic v;
    chk("job_rdy_pre", 32'(job_rdy), 32'd1);
    job_vld  = 1'b1;
    job_mode = mode;
    job_k    = 7'(k);
    job_n    = (SW+1)'(n);
    tick(1'b0);
    job_vld = 1'b0;
    chk("in_rdy_run", 32'(in_rdy), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    chk("job_rdy_run", 32'(job_rdy), 32'd0);
    total = k * n;
    beats = 0;
    cyc   = 0;
    while (beats < total) begin
      v = !(bub && (cyc % 2 == 1));
      if (v) begin
        sb_q.push_back(beat_exp(mode, k, n, beats));
        beats++;
      end
      in_vld = v;
      tick(v);
      cyc++;
      if (beats < total) chk("in_rdy_mid", 32'(in_rdy), 32'd1);
    end
    in_vld = 1'b0;
    chk("flush_in_rdy", 32'(in_rdy), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_done_early", 32'(done), 32'd0);
    tick(1'b0);
    chk("done", 32'(done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_job_rdy", 32'(job_rdy), 32'd0);
    tick(1'b0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_job_rdy", 32'(job_rdy), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic reject_job(input logic mode, input int k, input int n);
    job_vld  = 1'b1;
    job_mode = mode;
    job_k    = 7'(k);
    job_n    = (SW+1)'(n);
    in_vld   = 1'b1;
    tick(1'b0);
    job_vld = 1'b0;
    chk("rej_done", 32'(done), 32'd1);
    chk("rej_err", 32'(err), 32'd1);
    chk("rej_job_rdy", 32'(job_rdy), 32'd1);
    chk("rej_busy", 32'(busy), 32'd0);
    chk("rej_in_rdy", 32'(in_rdy), 32'd0);
    tick(1'b0);
    in_vld = 1'b0;
    chk("rej_done_pulse", 32'(done), 32'd0);
    chk("rej_err_pulse", 32'(err), 32'd0);
    chk("rej_job_rdy2", 32'(job_rdy), 32'd1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    exp_sel   = '0;
    exp_sel_d = '0;
    rst       = 1'b1;
    job_vld   = 1'b0;
    job_mode  = 1'b0;
    job_k     = '0;
    job_n     = '0;
    in_vld    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sel_delay", 32'(sel_delay), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_job_rdy", 32'(job_rdy), 32'd1);
    rst = 1'b0;
    tick(1'b0);
    chk("idle_job_rdy", 32'(job_rdy), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Average, K=4 N=3, full throughput.
    run_job(1'b0, 4, 3, 1'b0);
    // Max, K=1 N=16: every command start|end, sel wraps 15 -> 0.
    run_job(1'b1, 1, 16, 1'b0);
    // Average K=2 N=2 with alternate bubbles.
    run_job(1'b0, 2, 2, 1'b1);

    reject_job(1'b0, 0, 3);
    reject_job(1'b1, 4, 17);
    reject_job(1'b0, 65, 1);
    reject_job(1'b1, 5, 0);

    // Back-to-back: second job issued the cycle job_rdy returns.
    run_job(1'b1, 127, 1, 1'b0);
    run_job(1'b0, 64, 16, 1'b0);

    // Reset in the middle of a job.
    job_vld  = 1'b1;
    job_mode = 1'b0;
    job_k    = 7'd4;
    job_n    = 5'd3;
    tick(1'b0);
    job_vld = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sb_q.push_back(beat_exp(1'b0, 4, 3, b));
      in_vld = 1'b1;
      tick(1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cmd", 32'(cmd), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_job_rdy", 32'(job_rdy), 32'd1);
    chk("arst_in_rdy", 32'(in_rdy), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    exp_sel   = '0;
    exp_sel_d = '0;
    tick(1'b0);
    chk("arst_no_done", 32'(done), 32'd0);
    chk("arst_idle", 32'(job_rdy), 32'd1);
    // Counters must restart cleanly after the abandoned job.
    run_job(1'b0, 4, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
